mlp_batch_sequencer: RTL and testbench

Batch scheduler that drives the MLP top-level start/done handshake over a contiguous range of test samples. It issues one inference per sample and compares each result with a label ROM. Results are pushed into a small result FIFO with a valid/ready drain. The block sits between the system command interface and a single MLP instance, and keeps a running count of correct classifications.

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/result_fifo.sv | 48 ++++
 rtl/mlp_batch_sequencer.sv | 157 +++++++++++++++
 tb/tb_mlp_batch_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types for the MLP batch sequencer: sequencer states and the result
// entry stored in the result FIFO.
package mlp_pkg;

  localparam int IDX_W = 10;
  localparam int CLS_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_PUSH   = 3'd3,
    S_FINISH = 3'd4,
    S_ERR    = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CLS_W-1:0] cls;
    logic             match;
  } seq_result_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of sequencer results with full/empty flags; the head entry
// is presented combinationally on rd_data.
module result_fifo
  import mlp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  seq_result_t wr_data,
  input  logic        rd_en,
  output seq_result_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seq_result_t    mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mlp_batch_sequencer.sv
// Batch scheduler: runs one MLP inference per sample over a contiguous index
// range, scores each class against a label ROM and queues the results.
module mlp_batch_sequencer
  import mlp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_base,
  input  logic [IDX_W:0]   cmd_count,
  output logic             mlp_start,
  output logic [IDX_W-1:0] mlp_test_num,
  input  logic [CLS_W-1:0] mlp_out,
  input  logic             mlp_done,
  output logic [IDX_W-1:0] label_addr,
  input  logic [CLS_W-1:0] label_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_idx,
  output logic [CLS_W-1:0] res_class,
  output logic             res_match,
  output logic             busy,
  output logic             batch_done,
  output logic [IDX_W:0]   correct_cnt,
  output logic             timeout_err,
  output seq_state_t       dbg_state
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  seq_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W:0]    remaining_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CLS_W-1:0]  cls_q;
  logic              match_q;
  logic              mlp_start_q;
  logic              batch_done_q;
  logic [IDX_W:0]    correct_q;
  logic              timeout_err_q;

  seq_result_t       push_entry;
  seq_result_t       head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;

  // Result handshake: an entry transfers on a rising clk edge where res_valid
  // and res_ready are both high; res_valid never depends on res_ready, and the
  // head entry stays stable while res_valid is high and res_ready is low.
  assign push_req   = (state_q == S_PUSH);
  assign push_entry = '{idx: idx_q, cls: cls_q, match: match_q};

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_req),
    .wr_data (push_entry),
    .rd_en   (res_ready),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      remaining_q   <= '0;
      wait_q        <= '0;
      cls_q         <= '0;
      match_q       <= 1'b0;
      mlp_start_q   <= 1'b0;
      batch_done_q  <= 1'b0;
      correct_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      mlp_start_q  <= 1'b0;
      batch_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            idx_q         <= cmd_base;
            remaining_q   <= cmd_count;
            correct_q     <= '0;
            timeout_err_q <= 1'b0;
            if (cmd_count == '0) begin
              state_q      <= S_FINISH;
              batch_done_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              mlp_start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving in the timeout cycle still counts.
          if (mlp_done) begin
            cls_q   <= mlp_out;
            match_q <= (mlp_out == label_data);
            state_q <= S_PUSH;
          end else if (wait_q == TIMEOUT_C) begin
            state_q       <= S_ERR;
            timeout_err_q <= 1'b1;
            batch_done_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_PUSH: begin
          if (!fifo_full) begin
            correct_q   <= correct_q + {{IDX_W{1'b0}}, match_q};
            idx_q       <= idx_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == (IDX_W+1)'(1)) begin
              state_q      <= S_FINISH;
              batch_done_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              mlp_start_q <= 1'b1;
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        S_ERR:    state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign mlp_start    = mlp_start_q;
  assign mlp_test_num = idx_q;
  assign label_addr   = idx_q;
  assign batch_done   = batch_done_q;
  assign correct_cnt  = correct_q;
  assign timeout_err  = timeout_err_q;
  assign dbg_state    = state_q;

  assign res_valid = !fifo_empty;
  assign res_idx   = head_entry.idx;
  assign res_class = head_entry.cls;
  assign res_match = head_entry.match;

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Bench for mlp_batch_sequencer: behavioural MLP and label ROM, result
// scoreboard, table-driven batches, directed corner cases and random batches.
`timescale 1ns/1ps
module tb_mlp_batch_sequencer;
  import mlp_pkg::*;

  localparam int TO    = 20;
  localparam int DEPTH = 4;
  localparam int EW    = IDX_W + CLS_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_base  = '0;
  logic [IDX_W:0]   cmd_count = '0;
  logic             mlp_start;
  logic [IDX_W-1:0] mlp_test_num;
  logic [CLS_W-1:0] mlp_out   = '0;
  logic             mlp_done  = 1'b0;
  logic [IDX_W-1:0] label_addr;
  logic [CLS_W-1:0] label_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [IDX_W-1:0] res_idx;
  logic [CLS_W-1:0] res_class;
  logic             res_match;
  logic             busy;
  logic             batch_done;
  logic [IDX_W:0]   correct_cnt;
  logic             timeout_err;
  seq_state_t       dbg_state;

  mlp_batch_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_count    (cmd_count),
    .mlp_start    (mlp_start),
    .mlp_test_num (mlp_test_num),
    .mlp_out      (mlp_out),
    .mlp_done     (mlp_done),
    .label_addr   (label_addr),
    .label_data   (label_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_idx      (res_idx),
    .res_class    (res_class),
    .res_match    (res_match),
    .busy         (busy),
    .batch_done   (batch_done),
    .correct_cnt  (correct_cnt),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- environment models ----------------
  logic [CLS_W-1:0] cls_tab   [1024];
  logic [CLS_W-1:0] label_rom [1024];
  int               mlp_lat = 1;
  int               mlp_cnt = -1;
  logic [IDX_W-1:0] mlp_num = '0;
  logic [IDX_W-1:0] addr_d1 = '0;

  // MLP: done arrives mlp_lat cycles after the start cycle (0 = never).
  initial forever begin
    @(negedge clk);
    mlp_done   = 1'b0;
    mlp_out    = CLS_W'($urandom);
    label_data = label_rom[addr_d1];
    addr_d1    = label_addr;
    if (!rst) begin
      mlp_cnt = -1;
    end else if (mlp_start) begin
      mlp_num = mlp_test_num;
      mlp_cnt = (mlp_lat > 0) ? mlp_lat : -1;
    end else if (mlp_cnt > 0) begin
      mlp_cnt--;
      if (mlp_cnt == 0) begin
        mlp_done = 1'b1;
        mlp_out  = cls_tab[mlp_num];
        mlp_cnt  = -1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0]    exp_q [$];
  logic [IDX_W-1:0] start_q [$];
  logic [IDX_W-1:0] exp_start [$];
  logic [EW-1:0]    got;
  logic [EW-1:0]    want;
  int   accept_cyc = 0;
  int   first_start_cyc = -1;
  int   first_valid_cyc = -1;
  int   done_pulses = 0;
  int   done_cyc = 0;
  int   done_correct = 0;
  logic done_terr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (cmd_valid && cmd_ready) accept_cyc = cyc;
      if (mlp_start) begin
        start_q.push_back(mlp_test_num);
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (batch_done) begin
        done_pulses++;
        done_cyc     = cyc;
        done_correct = int'(correct_cnt);
        done_terr    = timeout_err;
      end
      if (res_valid && res_ready) begin
        got = {res_idx, res_class, res_match};
        if (exp_q.size() == 0) begin
          check("res_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("res_entry", 32'(got), 32'(want));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic expect_batch(input int base, input int count, output int corr);
    int   idx;
    logic m;
    corr = 0;
    exp_start.delete();
    for (int i = 0; i < count; i++) begin
      idx = (base + i) % 1024;
      m   = (cls_tab[idx] == label_rom[idx]);
      exp_q.push_back({IDX_W'(idx), cls_tab[idx], m});
      exp_start.push_back(IDX_W'(idx));
      corr += int'(m);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int base, input int count);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_base  = IDX_W'(base);
    cmd_count = (IDX_W+1)'(count);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_base  = IDX_W'($urandom);
    cmd_count = (IDX_W+1)'($urandom);
  endtask

  task automatic wait_done(input int pulses0, input int budget, output bit seen);
    int n;
    n = 0;
    while (done_pulses == pulses0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    seen = (done_pulses != pulses0);
  endtask

  task automatic run_batch(input int base, input int count, input int lat,
                           input int exp_off, input int exp_corr, input bit timed);
    int corr, pulses0, n;
    bit seen;
    mlp_lat = lat;
    start_q.delete();
    first_start_cyc = -1;
    first_valid_cyc = -1;
    expect_batch(base, count, corr);
    pulses0 = done_pulses;
    send_cmd(base, count);
    if (count > 0) begin
      // A command offered while busy must be ignored.
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    wait_done(pulses0, 3000, seen);
    check("batch_done_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (timed) check("done_latency", 32'(done_cyc - accept_cyc), 32'(exp_off));
    check("correct_cnt", 32'(done_correct), 32'(corr));
    if (exp_corr >= 0) check("correct_cnt_tbl", 32'(done_correct), 32'(exp_corr));
    check("timeout_err_clear", 32'(done_terr), 32'd0);
    if (timed && count > 0) begin
      check("start_latency", 32'(first_start_cyc - accept_cyc), 32'd1);
      check("valid_latency", 32'(first_valid_cyc - accept_cyc), 32'(lat + 3));
    end
    check("start_count", 32'(start_q.size()), 32'(count));
    for (int i = 0; i < count && i < start_q.size(); i++)
      check("start_idx", 32'(start_q[i]), 32'(exp_start[i]));
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("done_once", 32'(done_pulses - pulses0), 32'd1);
  endtask

  typedef struct {
    int base;
    int count;
    int lat;
    int exp_off;
    int exp_corr;
  } vec_t;

  vec_t tbl [6];
  bit   rand_ready = 1'b0;

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   corr, pulses0, n;
    bit   seen;

    for (int i = 0; i < 1024; i++) begin
      cls_tab[i]   = CLS_W'($urandom);
      label_rom[i] = CLS_W'($urandom);
    end
    cls_tab[5] = 4'h3; cls_tab[6] = 4'h3; cls_tab[7] = 4'h3;
    label_rom[5] = 4'h3; label_rom[6] = 4'hC; label_rom[7] = 4'h3;

    tbl[0] = '{5,    3, 10, 37, 2};
    tbl[1] = '{0,    0, 10, 1,  0};
    tbl[2] = '{1022, 4, 3,  21, -1};
    tbl[3] = '{100,  1, 1,  4,  -1};
    tbl[4] = '{700,  1, 21, 24, -1};
    tbl[5] = '{200,  8, 2,  33, -1};

    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start",   32'(mlp_start), 32'd0);
    check("rst_testnum", 32'(mlp_test_num), 32'd0);
    check("rst_valid",   32'(res_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(batch_done), 32'd0);
    check("rst_correct", 32'(correct_cnt), 32'd0);
    check("rst_terr",    32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    check("state_after_rst", 32'(dbg_state), 32'(S_IDLE));

    // Table-driven batches, results drained immediately
    foreach (tbl[i])
      run_batch(tbl[i].base, tbl[i].count, tbl[i].lat, tbl[i].exp_off, tbl[i].exp_corr, 1'b1);

    // Backpressure: FIFO fills, fifth result held in PUSH
    res_ready = 1'b0;
    mlp_lat   = 2;
    start_q.delete();
    expect_batch(900, 6, corr);
    pulses0 = done_pulses;
    send_cmd(900, 6);
    repeat (40) @(posedge clk);
    #2;
    check("bp_starts",  32'(start_q.size()), 32'd5);
    check("bp_state",   32'(dbg_state), 32'(S_PUSH));
    check("bp_busy",    32'(busy), 32'd1);
    check("bp_valid",   32'(res_valid), 32'd1);
    check("bp_head",    32'(res_idx), 32'd900);
    check("bp_no_done", 32'(done_pulses - pulses0), 32'd0);
    res_ready = 1'b1;
    wait_done(pulses0, 200, seen);
    check("bp_done_seen", 32'(seen), 32'd1);
    check("bp_correct",   32'(done_correct), 32'(corr));
    check("bp_starts_all", 32'(start_q.size()), 32'd6);
    repeat (6) @(posedge clk);
    #2;
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_done_once", 32'(done_pulses - pulses0), 32'd1);

    // Timeout: MLP never completes
    mlp_lat = 0;
    start_q.delete();
    first_start_cyc = -1;
    pulses0 = done_pulses;
    send_cmd(50, 3);
    wait_done(pulses0, 100, seen);
    check("to_done_seen", 32'(seen), 32'd1);
    check("to_latency",   32'(done_cyc - first_start_cyc), 32'd22);
    check("to_flag",      32'(done_terr), 32'd1);
    check("to_starts",    32'(start_q.size()), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("to_sticky",    32'(timeout_err), 32'd1);
    check("to_idle",      32'(cmd_ready), 32'd1);
    check("to_done_once", 32'(done_pulses - pulses0), 32'd1);
    run_batch(60, 2, 3, 1 + 2 * 5, -1, 1'b1);

    // Reset in the middle of a wait
    mlp_lat = 10;
    start_q.delete();
    expect_batch(300, 4, corr);
    send_cmd(300, 4);
    n = 0;
    while (start_q.size() < 2 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_starts", 32'(start_q.size()), 32'd2);
    repeat (3) @(posedge clk);
    #3;
    check("mid_in_wait", 32'(dbg_state), 32'(S_WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_start",   32'(mlp_start), 32'd0);
    check("mid_rst_testnum", 32'(mlp_test_num), 32'd0);
    check("mid_rst_valid",   32'(res_valid), 32'd0);
    check("mid_rst_busy",    32'(busy), 32'd0);
    check("mid_rst_done",    32'(batch_done), 32'd0);
    check("mid_rst_correct", 32'(correct_cnt), 32'd0);
    check("mid_rst_terr",    32'(timeout_err), 32'd0);
    check("mid_rst_ready",   32'(cmd_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    run_batch(600, 2, 4, 1 + 2 * 6, -1, 1'b1);

    // Random batches with random drain backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++)
      run_batch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 9)),
                int'($urandom_range(1, 6)), 0, -1, 1'b0);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
